alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Arbitrates two requesters onto one shared, purely combinational ALU.
//   A granted operation's result is captured on the issue edge. It is then
//   held in RspData/RspValid until the granted requester takes it. The
//   throughput limit is one operation per two cycles (IDLE -> RESP -> IDLE).
//
// Parameters
//   DATA_W  operand / result width
//   CNT_W   width of the completed-operation counter (wraps silently)
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   ReqValid[1:0]          requester i presents an operation
//   ReqReady[1:0]          requester i's operation accepted this cycle
//   ReqA/ReqB[2*DATA_W]    operands, requester i in [i*DATA_W +: DATA_W]
//   ReqSel[7:0]            ALU select, requester i in [i*4 +: 4]
//   AluA/AluB/AluSel       drive the shared ALU (zero when not issuing)
//   AluResult              combinational ALU result for AluA/AluB/AluSel
//   RspValid[1:0]          one-hot: RspData belongs to requester i
//   RspReady[1:0]          requester i accepts the response
//   RspData                registered result shared by both requesters
//   OpCount                number of completed response handshakes
//
// Configuration
//   ALU_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins contention
//                          and no last-grant state is kept. Otherwise the
//                          arbiter is round-robin.
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            ReqValid,
    output logic [1:0]            ReqReady,
    input  logic [2*DATA_W-1:0]   ReqA,
    input  logic [2*DATA_W-1:0]   ReqB,
    input  logic [7:0]            ReqSel,
    output logic [DATA_W-1:0]     AluA,
    output logic [DATA_W-1:0]     AluB,
    output logic [3:0]            AluSel,
    input  logic [DATA_W-1:0]     AluResult,
    output logic [1:0]            RspValid,
    input  logic [1:0]            RspReady,
    output logic [DATA_W-1:0]     RspData,
    output logic [CNT_W-1:0]      OpCount
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    // Per-requester view of the packed request buses
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [3:0]        sel;
    } alu_req_t;

    alu_req_t [1:0]    w_req;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_rsp_data;
    logic [1:0]        r_rsp_valid;
    logic [CNT_W-1:0]  r_op_count;

    logic              w_grant;      // index of the winning requester
    logic              w_issue;      // an operation is accepted this cycle
    logic              w_rsp_done;   // response handshake this cycle

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign w_req[gi].a   = ReqA[gi*DATA_W +: DATA_W];
            assign w_req[gi].b   = ReqB[gi*DATA_W +: DATA_W];
            assign w_req[gi].sel = ReqSel[gi*4 +: 4];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it is valid.
    assign w_grant = ~ReqValid[0];
`else
    logic r_last_grant;

    always_comb begin
        w_grant = 1'b0;
        case (ReqValid)
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~r_last_grant;  // whoever did not win last time
            default: w_grant = 1'b0;
        endcase
    end

    // Reset value of 1 lets requester 0 win the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last_grant <= 1'b1;
        else if (w_issue)
            r_last_grant <= w_grant;
    end
`endif

    // The state register is forced to IDLE asynchronously. rst_n is also
    // gated in here so that ReqReady cannot pulse while reset is held and
    // ReqValid is high.
    assign w_issue    = rst_n && (r_state == S_IDLE) && (|ReqValid);
    // Only the granted bit of RspReady counts. RspValid is one-hot, so the
    // AND masks off the other requester.
    assign w_rsp_done = (r_state == S_RESP) && (|(r_rsp_valid & RspReady));

    // ------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        ReqReady    = 2'b00;
        AluA        = '0;
        AluB        = '0;
        AluSel      = 4'b0000;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    ReqReady[w_grant] = 1'b1;
                    AluA              = w_req[w_grant].a;
                    AluB              = w_req[w_grant].b;
                    AluSel            = w_req[w_grant].sel;
                    w_state_nxt       = S_RESP;
                end
            end
            S_RESP: begin
                // Requests are ignored here. A new grant can only happen
                // after returning to IDLE.
                if (w_rsp_done)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rsp_data  <= '0;
            r_rsp_valid <= 2'b00;
            r_op_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_rsp_data  <= AluResult;
                r_rsp_valid <= w_grant ? 2'b10 : 2'b01;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 2'b00;
                r_op_count  <= r_op_count + CNT_W'(1);  // wraps to 0
            end
        end
    end

    assign RspValid = r_rsp_valid;
    assign RspData  = r_rsp_data;
    assign OpCount  = r_op_count;

endmodule
